// File: rtl/id_alu_decode_if.sv
// ID -> EX handshake and decoded-payload bundle for the RV32I ALU decode stage.
// master drives the ID side and consumes EX; slave is the decode stage itself.
interface id_alu_decode_if;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        ex_ready;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic [3:0]  alu_funct;
  logic [1:0]  ex_a_sel;
  logic        ex_b_imm;
  logic [31:0] ex_imm;
  logic        ex_illegal;

  modport master (
    output flush, id_valid, id_inst, ex_ready,
    input  id_ready, ex_valid, ex_alu_op, alu_funct, ex_a_sel, ex_b_imm,
           ex_imm, ex_illegal
  );

  modport slave (
    input  flush, id_valid, id_inst, ex_ready,
    output id_ready, ex_valid, ex_alu_op, alu_funct, ex_a_sel, ex_b_imm,
           ex_imm, ex_illegal
  );
endinterface

// File: rtl/id_alu_decode.sv
// RV32I decode into EX-stage ALU control, operand selects and immediate,
// held in one ID/EX register with valid/ready handshake and synchronous flush.
module id_alu_decode (
  input  logic           clk,
  input  logic           rst_n,
  id_alu_decode_if.slave bus
);

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign inst   = bus.id_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Shift-right and add/sub are the only funct3 values that carry an alternate form.
  logic alt_f3;
  assign alt_f3 = (funct3 == 3'b000) || (funct3 == 3'b101);

  logic [1:0]  alu_op_d,  alu_op_q;
  logic [3:0]  funct_d,   funct_q;
  a_sel_e      a_sel_d,   a_sel_q;
  logic        b_imm_d,   b_imm_q;
  logic [31:0] imm_d,     imm_q;
  logic        illegal_d, illegal_q;
  logic        valid_q;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // opcode path can leave a signal unassigned and infer a latch.
    alu_op_d  = ALU_OP_ADD;
    funct_d   = 4'b0000;
    a_sel_d   = A_RS1;
    b_imm_d   = 1'b0;
    imm_d     = '0;
    illegal_d = 1'b0;

    case (opcode)
      OPC_OP: begin
        alu_op_d  = ALU_OP_R;
        funct_d   = {inst[30], funct3};
        illegal_d = !((funct7 == F7_ZERO) || ((funct7 == F7_ALT) && alt_f3));
      end
      OPC_OP_IMM: begin
        alu_op_d = ALU_OP_I;
        funct_d  = {alt_f3 ? inst[30] : 1'b0, funct3};
        b_imm_d  = 1'b1;
        imm_d    = imm_i;
        if (funct3 == 3'b001)
          illegal_d = (funct7 != F7_ZERO);
        else if (funct3 == 3'b101)
          illegal_d = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
      end
      OPC_LOAD: begin
        b_imm_d = 1'b1;
        imm_d   = imm_i;
      end
      OPC_STORE: begin
        b_imm_d = 1'b1;
        imm_d   = imm_s;
      end
      OPC_BRANCH: begin
        alu_op_d  = ALU_OP_SUB;
        funct_d   = {1'b0, funct3};
        imm_d     = imm_b;
        illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LUI: begin
        a_sel_d = A_ZERO;
        b_imm_d = 1'b1;
        imm_d   = imm_u;
      end
      OPC_AUIPC: begin
        a_sel_d = A_PC;
        b_imm_d = 1'b1;
        imm_d   = imm_u;
      end
      OPC_JAL: begin
        a_sel_d = A_PC;
        b_imm_d = 1'b1;
        imm_d   = imm_j;
      end
      OPC_JALR: begin
        b_imm_d   = 1'b1;
        imm_d     = imm_i;
        illegal_d = (funct3 != 3'b000);
      end
      default: illegal_d = 1'b1;
    endcase

    // Illegal entries present a harmless add of zero to EX.
    if (illegal_d) begin
      alu_op_d = ALU_OP_ADD;
      funct_d  = 4'b0000;
      a_sel_d  = A_RS1;
      b_imm_d  = 1'b0;
      imm_d    = '0;
    end
  end

  logic id_ready;
  logic capture;

  assign id_ready = !valid_q || bus.ex_ready;
  assign capture  = bus.id_valid && id_ready && !bus.flush;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order within the block.
    if (!rst_n) begin
      // NOTE: the payload is reset too, not just the valid bit, because EX may
      // observe the fields while ex_valid is low and expects defined values.
      valid_q   <= 1'b0;
      alu_op_q  <= ALU_OP_ADD;
      funct_q   <= 4'b0000;
      a_sel_q   <= A_RS1;
      b_imm_q   <= 1'b0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      alu_op_q  <= alu_op_d;
      funct_q   <= funct_d;
      a_sel_q   <= a_sel_d;
      b_imm_q   <= b_imm_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end else if (bus.ex_ready || !valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.ex_valid   = valid_q;
  assign bus.ex_alu_op  = alu_op_q;
  assign bus.alu_funct  = funct_q;
  assign bus.ex_a_sel   = a_sel_q;
  assign bus.ex_b_imm   = b_imm_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_illegal = illegal_q;

endmodule

// File: tb/tb_id_alu_decode.sv
// Directed bench for id_alu_decode: expected EX entries are queued at issue
// and compared when EX consumes them; stall, flush and reset checked inline.
module tb_id_alu_decode;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_I   = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  funct;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst_n;
  id_alu_decode_if bus ();

  id_alu_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t  sb_q[$];
  string sb_name_q[$];

  function automatic exp_t mk(input logic [1:0] op, input logic [3:0] funct,
                              input logic [1:0] a_sel, input logic b_imm,
                              input logic [31:0] imm, input logic illegal);
    exp_t e;
    e.op = op; e.funct = funct; e.a_sel = a_sel;
    e.b_imm = b_imm; e.imm = imm; e.illegal = illegal;
    return e;
  endfunction

  function automatic exp_t observed();
    return mk(bus.ex_alu_op, bus.alu_funct, bus.ex_a_sel, bus.ex_b_imm,
              bus.ex_imm, bus.ex_illegal);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string name, input exp_t e);
    sb_q.push_back(e);
    sb_name_q.push_back(name);
  endtask

  task automatic discard();
    if (sb_q.size() != 0) begin
      void'(sb_q.pop_front());
      void'(sb_name_q.pop_front());
    end
  endtask

  // Inputs change at posedge+1, so this sees the values that the next edge will use.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_entry", 64'(bus.ex_valid), 64'(1'b0));
      end else begin
        exp_t  e;
        string n;
        e = sb_q.pop_front();
        n = sb_name_q.pop_front();
        check({"sb_", n}, 64'(observed()), 64'(e));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
    bus.id_valid = v;
    bus.id_inst  = inst;
    bus.ex_ready = rdy;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_ADDI  = 32'hFFF00093;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_BEQ   = 32'hFE000CE3;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_ZERO  = 32'h00000000;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_SLLIX = 32'h40109093;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_XOR   = 32'h0020C1B3;
  localparam logic [31:0] I_OR    = 32'h0020E1B3;
  localparam logic [31:0] I_AND   = 32'h0020F1B3;
  localparam logic [31:0] I_SLT   = 32'h0020A1B3;

  initial begin
    exp_t rst_e, ill_e, add_e, xor_e;
    rst_e = mk(OP_ADD, 4'b0000, 2'd0, 1'b0, 32'h0, 1'b0);
    ill_e = mk(OP_ADD, 4'b0000, 2'd0, 1'b0, 32'h0, 1'b1);
    add_e = mk(OP_R,   4'b0000, 2'd0, 1'b0, 32'h0, 1'b0);
    xor_e = mk(OP_R,   4'b0100, 2'd0, 1'b0, 32'h0, 1'b0);

    rst_n = 1'b0;
    bus.id_valid = 1'b0; bus.id_inst = '0; bus.ex_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ex_valid", 64'(bus.ex_valid), 64'(1'b0));
    check("reset_payload", 64'(observed()), 64'(rst_e));
    check("reset_id_ready", 64'(bus.id_ready), 64'(1'b1));
    rst_n = 1'b1;

    // Back-to-back stream with EX always ready.
    push("sub",   mk(OP_R,   4'b1000, 2'd0, 1'b0, 32'h0,        1'b0)); drive(1, I_SUB, 1, 0);
    check("sub_latency_valid", 64'(bus.ex_valid), 64'(1'b1));
    push("addi",  mk(OP_I,   4'b1000, 2'd0, 1'b1, 32'hFFFFFFFF, 1'b0)); drive(1, I_ADDI, 1, 0);
    push("srai",  mk(OP_I,   4'b1101, 2'd0, 1'b1, 32'h00000403, 1'b0)); drive(1, I_SRAI, 1, 0);
    push("beq",   mk(OP_SUB, 4'b0000, 2'd0, 1'b0, 32'hFFFFFFF8, 1'b0)); drive(1, I_BEQ, 1, 0);
    push("lui",   mk(OP_ADD, 4'b0000, 2'd2, 1'b1, 32'h12345000, 1'b0)); drive(1, I_LUI, 1, 0);
    push("auipc", mk(OP_ADD, 4'b0000, 2'd1, 1'b1, 32'h00001000, 1'b0)); drive(1, I_AUIPC, 1, 0);
    push("jal",   mk(OP_ADD, 4'b0000, 2'd1, 1'b1, 32'h00000008, 1'b0)); drive(1, I_JAL, 1, 0);
    push("jalr",  mk(OP_ADD, 4'b0000, 2'd0, 1'b1, 32'h00000000, 1'b0)); drive(1, I_JALR, 1, 0);
    push("sw",    mk(OP_ADD, 4'b0000, 2'd0, 1'b1, 32'h00000004, 1'b0)); drive(1, I_SW, 1, 0);
    push("ill_zero", ill_e); drive(1, I_ZERO, 1, 0);
    push("ill_mul",  ill_e); drive(1, I_MUL, 1, 0);
    push("ill_slli", ill_e); drive(1, I_SLLIX, 1, 0);
    drive(0, '0, 1, 0);
    check("idle_valid_drops", 64'(bus.ex_valid), 64'(1'b0));

    // Stall: ADD held while EX is not ready and ID keeps offering XOR.
    push("add", add_e); drive(1, I_ADD, 1, 0);
    bus.id_inst = I_XOR; bus.ex_ready = 1'b0;
    #1;
    check("stall_id_ready_low", 64'(bus.id_ready), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid_held", 64'(bus.ex_valid), 64'(1'b1));
      check("stall_payload_held", 64'(observed()), 64'(add_e));
      check("stall_id_ready", 64'(bus.id_ready), 64'(1'b0));
    end
    push("xor", xor_e);
    bus.ex_ready = 1'b1;
    #1;
    check("release_id_ready", 64'(bus.id_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    check("no_bubble_valid", 64'(bus.ex_valid), 64'(1'b1));
    check("no_bubble_payload", 64'(observed()), 64'(xor_e));
    drive(0, '0, 1, 0);

    // Flush with a held entry and a competing ID instruction.
    push("or", mk(OP_R, 4'b0110, 2'd0, 1'b0, 32'h0, 1'b0)); drive(1, I_OR, 1, 0);
    discard();
    drive(1, I_AND, 0, 1);
    check("flush_kills_valid", 64'(bus.ex_valid), 64'(1'b0));
    bus.flush = 1'b1;
    #1;
    check("id_ready_ignores_flush", 64'(bus.id_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    check("flush_drops_id", 64'(bus.ex_valid), 64'(1'b0));
    drive(0, '0, 1, 0);
    check("post_flush_idle", 64'(bus.ex_valid), 64'(1'b0));

    // Reset while an entry is stalled.
    push("slt", mk(OP_R, 4'b0010, 2'd0, 1'b0, 32'h0, 1'b0)); drive(1, I_SLT, 1, 0);
    drive(1, I_ADD, 0, 0);
    check("pre_reset_stall_valid", 64'(bus.ex_valid), 64'(1'b1));
    discard();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midstall_reset_valid", 64'(bus.ex_valid), 64'(1'b0));
    check("midstall_reset_payload", 64'(observed()), 64'(rst_e));
    rst_n = 1'b1;
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);

    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_alu_decode.md
# id_alu_decode

Decode stage that converts a 32-bit RV32I instruction into the ALU control fields consumed in EX: `ex_alu_op` and the 4-bit `alu_funct` that the EX-stage ALU control unit turns into `alu_sel`. It also generates the immediate and operand-select fields. Results are held in a single ID/EX pipeline register with a valid/ready handshake and a synchronous flush.

## Interface
- No parameters. Encodings come from `defines.v`: `ALU_OP_R`, `ALU_OP_I`, `ALU_OP_ADD`, `ALU_OP_SUB`, `ALU_ADD`=4'b0000, `ALU_SUB`=4'b1000.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `flush` in 1: kill the EX entry and any capture this cycle.
- `id_valid` in 1: the ID instruction is valid.
- `id_inst` in 32: instruction word.
- `id_ready` out 1: this block accepts `id_inst` this cycle.
- `ex_ready` in 1: EX consumes the current entry.
- `ex_valid` out 1: the EX entry is valid.
- `ex_alu_op` out 2: ALU operation class.
- `alu_funct` out 4: `{funct7[5]-derived bit, funct3}`.
- `ex_a_sel` out 2: operand A source. 0 = rs1, 1 = pc, 2 = zero.
- `ex_b_imm` out 1: 1 = operand B is `ex_imm`, 0 = rs2.
- `ex_imm` out 32: sign-extended immediate.
- `ex_illegal` out 1: the instruction is not a legal RV32I instruction.

## Operation
- Fields: opcode = `inst[6:0]`, funct3 = `inst[14:12]`, funct7 = `inst[31:25]`.
- OP (0110011):
  - `ALU_OP_R`, funct = `{inst[30], funct3}`, a_sel = 0, b_imm = 0.
  - Legal only when funct7 = 0000000, or funct7 = 0100000 with funct3 ∈ {000, 101}. Any other value, including M-extension encodings, is illegal.
- OP-IMM (0010011):
  - `ALU_OP_I`, a_sel = 0, b_imm = 1, I-immediate.
  - funct[2:0] = funct3. funct[3] = `inst[30]` when funct3 ∈ {000, 101}, else 0.
  - The EX-side unit masks `ALU_SUB` under `ALU_OP_I`, so ADDI with imm[10]=1 is correct.
  - funct3 = 001 requires funct7 = 0. funct3 = 101 requires funct7 ∈ {0000000, 0100000}. Otherwise the instruction is illegal.
- LOAD (0000011): `ALU_OP_ADD`, a_sel = 0, b_imm = 1, I-immediate.
- STORE (0100011): same as LOAD, but with the S-immediate.
- BRANCH (1100011): `ALU_OP_SUB`, funct = `{1'b0, funct3}`, a_sel = 0, b_imm = 0, B-immediate. funct3 ∈ {010, 011} is illegal.
- LUI (0110111): `ALU_OP_ADD`, a_sel = 2, b_imm = 1, U-immediate.
- AUIPC (0010111): `ALU_OP_ADD`, a_sel = 1, b_imm = 1, U-immediate.
- JAL (1101111): `ALU_OP_ADD`, a_sel = 1, b_imm = 1, J-immediate.
- JALR (1100111): `ALU_OP_ADD`, a_sel = 0, b_imm = 1, I-immediate. funct3 ≠ 000 is illegal.
- Any other opcode: illegal.
- Illegal entries: `ALU_OP_ADD`, funct 0000, a_sel 0, b_imm 0, imm 0, `ex_illegal` = 1.
- For legal entries, funct is 0000 wherever it is not specified above.
- Immediates are sign-extended from `inst[31]`. B and J immediates have bit 0 = 0. U-immediate = `{inst[31:12], 12'b0}`.

## Timing
- Latency: one cycle from the capture edge to `ex_*` valid.
- `id_ready` = `!ex_valid || ex_ready`. It is combinational and does not depend on `flush`.
- Capture happens when `id_valid && id_ready && !flush`.
  - Payload registers load the decoded fields.
  - `ex_valid` ← 1.
- Otherwise:
  - If `ex_ready`, or if `ex_valid` = 0, then `ex_valid` ← 0.
  - If `ex_valid && !ex_ready`, the entry holds. Payload and `ex_valid` stay stable until consumed.
- Flush has top priority. It forces `ex_valid` ← 0 next cycle and drops any same-cycle ID instruction. Payload registers may keep their old values.
- Simultaneous consume and capture (`ex_valid && ex_ready && id_valid`): the new entry replaces the old one with no bubble.
- Reset (`rst_n` = 0 at an edge) has priority over flush and capture. It sets:
  - `ex_valid` = 0, `ex_alu_op` = `ALU_OP_ADD`, `alu_funct` = 0, `ex_a_sel` = 0, `ex_b_imm` = 0, `ex_imm` = 0, `ex_illegal` = 0.
- Reset mid-stall discards the held entry.
- Payload outputs change only on a capture edge or on reset.

## Test plan
- SUB x3,x1,x2 (0x402081B3), `ex_ready` = 1 → next cycle `ex_valid` = 1, `ALU_OP_R`, funct 4'b1000, a_sel 0, b_imm 0, illegal 0.
- ADDI x1,x0,-1 (0xFFF00093) → `ALU_OP_I`, funct 4'b1000, b_imm 1, imm 0xFFFFFFFF. SRAI x1,x1,3 (0x4030D093) → funct 4'b1101, imm 0x00000403.
- BEQ with offset -8 (0xFE000CE3), then LUI x5,0x12345 (0x123452B7):
  - BEQ → `ALU_OP_SUB`, funct 0000, imm 0xFFFFFFF8.
  - LUI → `ALU_OP_ADD`, a_sel 2, imm 0x12345000.
- Stall: capture ADD, hold `ex_ready` = 0 for 3 cycles while `id_valid` = 1 → `id_ready` = 0 and outputs are unchanged. Raise `ex_ready` → next instruction captured with no bubble.
- Flush while `ex_valid` = 1 and `id_valid` = 1 → next cycle `ex_valid` = 0 and the ID instruction is not captured. Same check with reset asserted mid-stall → all outputs reach their reset values.
- Illegal cases: 0x00000000, MUL (0x022081B3), SLLI with funct7 = 0100000 (0x40109093) → each gives `ex_illegal` = 1, `ALU_OP_ADD`, funct 0.
